// File: rtl/router_fsm.sv
// router_fsm: packet router control FSM. It decodes the header address and sequences FIFO
// loading, back-pressure and the parity check for one packet at a time.
`default_nettype none

module router_fsm #(
   parameter logic [1:0] INVALID_ADDR = 2'b11
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       pkt_valid,
   input  logic [1:0] data_in,
   input  logic       fifo_full,
   input  logic       fifo_empty_0,
   input  logic       fifo_empty_1,
   input  logic       fifo_empty_2,
   input  logic       soft_reset_0,
   input  logic       soft_reset_1,
   input  logic       soft_reset_2,
   input  logic       parity_done,
   input  logic       low_pkt_valid,
   output logic       detect_add,
   output logic       lfd_state,
   output logic       ld_state,
   output logic       laf_state,
   output logic       full_state,
   output logic       write_enb_reg,
   output logic       rst_int_reg,
   output logic       busy
);

   localparam logic [2:0] DA  = 3'd0;
   localparam logic [2:0] LFD = 3'd1;
   localparam logic [2:0] LD  = 3'd2;
   localparam logic [2:0] WTE = 3'd3;
   localparam logic [2:0] FFS = 3'd4;
   localparam logic [2:0] LAF = 3'd5;
   localparam logic [2:0] LP  = 3'd6;
   localparam logic [2:0] CPE = 3'd7;

   logic [2:0] state, next_state;
   logic [1:0] addr;
   logic       live_empty, sel_empty, sel_soft_reset;

   // Header decisions use the live address; everything afterwards uses the latched one.
   always_comb begin
      live_empty = 1'b0;
      case (data_in)
         2'd0:    live_empty = fifo_empty_0;
         2'd1:    live_empty = fifo_empty_1;
         2'd2:    live_empty = fifo_empty_2;
         default: live_empty = 1'b0;
      endcase
   end

   always_comb begin
      sel_empty      = 1'b0;
      sel_soft_reset = 1'b0;
      case (addr)
         2'd0: begin sel_empty = fifo_empty_0; sel_soft_reset = soft_reset_0; end
         2'd1: begin sel_empty = fifo_empty_1; sel_soft_reset = soft_reset_1; end
         2'd2: begin sel_empty = fifo_empty_2; sel_soft_reset = soft_reset_2; end
         default: begin sel_empty = 1'b0; sel_soft_reset = 1'b0; end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= DA;
         addr  <= 2'b00;
      end else begin
         state <= next_state;
         if (state == DA && pkt_valid && data_in != INVALID_ADDR)
            addr <= data_in;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         DA:  if (pkt_valid && data_in != INVALID_ADDR)
                 next_state = live_empty ? LFD : WTE;
         LFD: next_state = LD;
         LD:  if (fifo_full)       next_state = FFS;
              else if (!pkt_valid) next_state = LP;
         FFS: if (!fifo_full)      next_state = LAF;
         LAF: if (parity_done)        next_state = DA;
              else if (low_pkt_valid) next_state = LP;
              else                    next_state = LD;
         LP:  next_state = CPE;
         CPE: next_state = fifo_full ? FFS : DA;
         WTE: if (sel_empty)       next_state = LFD;
         default: next_state = DA;
      endcase
      // A timeout on the selected port abandons the packet from any active state.
      if (state != DA && sel_soft_reset)
         next_state = DA;
   end

   always_comb begin
      detect_add    = 1'b0;
      lfd_state     = 1'b0;
      ld_state      = 1'b0;
      laf_state     = 1'b0;
      full_state    = 1'b0;
      write_enb_reg = 1'b0;
      rst_int_reg   = 1'b0;
      busy          = 1'b0;
      case (state)
         DA:  detect_add = 1'b1;
         LFD: begin lfd_state = 1'b1; busy = 1'b1; end
         LD:  begin ld_state = 1'b1; write_enb_reg = 1'b1; end
         WTE: busy = 1'b1;
         FFS: begin full_state = 1'b1; busy = 1'b1; end
         LAF: begin laf_state = 1'b1; write_enb_reg = 1'b1; busy = 1'b1; end
         LP:  begin write_enb_reg = 1'b1; busy = 1'b1; end
         CPE: begin rst_int_reg = 1'b1; busy = 1'b1; end
         default: detect_add = 1'b0;
      endcase
   end

endmodule

`default_nettype wire

// File: tb/tb_router_fsm.sv
// tb_router_fsm: directed and random stimulus for router_fsm, with every cycle compared
// against a named-state reference model.
`default_nettype none

module tb_router_fsm;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       pkt_valid = 1'b0;
   logic [1:0] data_in = 2'b00;
   logic       fifo_full = 1'b0;
   logic [2:0] empty = 3'b000;
   logic [2:0] sr = 3'b000;
   logic       parity_done = 1'b0;
   logic       low_pkt_valid = 1'b0;
   logic       detect_add, lfd_state, ld_state, laf_state, full_state;
   logic       write_enb_reg, rst_int_reg, busy;

   int total = 0;
   int bad = 0;

   typedef enum int {S_IDLE_DECODE, S_FIRST, S_BODY, S_WAIT_EMPTY, S_FULL,
                     S_AFTER_FULL, S_PARITY, S_CHECK} mstate_t;
   mstate_t    ms;
   logic [1:0] maddr;

   router_fsm dut (
      .clock(clock), .reset(reset), .pkt_valid(pkt_valid), .data_in(data_in),
      .fifo_full(fifo_full),
      .fifo_empty_0(empty[0]), .fifo_empty_1(empty[1]), .fifo_empty_2(empty[2]),
      .soft_reset_0(sr[0]), .soft_reset_1(sr[1]), .soft_reset_2(sr[2]),
      .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
      .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
      .laf_state(laf_state), .full_state(full_state),
      .write_enb_reg(write_enb_reg), .rst_int_reg(rst_int_reg), .busy(busy)
   );

   always #5 clock = ~clock;

   // Output vector order: detect_add, lfd, ld, laf, full, write_enb, rst_int, busy.
   function automatic logic [7:0] expected_outputs(mstate_t s);
      logic [7:0] v;
      v = 8'h00;
      if (s == S_IDLE_DECODE) v[7] = 1'b1;
      if (s == S_FIRST)       v[6] = 1'b1;
      if (s == S_BODY)        v[5] = 1'b1;
      if (s == S_AFTER_FULL)  v[4] = 1'b1;
      if (s == S_FULL)        v[3] = 1'b1;
      if (s inside {S_BODY, S_PARITY, S_AFTER_FULL}) v[2] = 1'b1;
      if (s == S_CHECK)       v[1] = 1'b1;
      if (!(s inside {S_IDLE_DECODE, S_BODY})) v[0] = 1'b1;
      return v;
   endfunction

   function automatic mstate_t model_next(mstate_t s, logic [1:0] a);
      mstate_t n;
      logic    port_timeout;
      port_timeout = (a != 2'b11) && sr[a];
      n = s;
      if (s != S_IDLE_DECODE && port_timeout) return S_IDLE_DECODE;
      case (s)
         S_IDLE_DECODE: if (pkt_valid && data_in != 2'b11)
                           n = empty[data_in] ? S_FIRST : S_WAIT_EMPTY;
         S_FIRST:       n = S_BODY;
         S_BODY:        n = fifo_full ? S_FULL : (!pkt_valid ? S_PARITY : S_BODY);
         S_FULL:        n = fifo_full ? S_FULL : S_AFTER_FULL;
         S_AFTER_FULL:  n = parity_done ? S_IDLE_DECODE :
                            (low_pkt_valid ? S_PARITY : S_BODY);
         S_PARITY:      n = S_CHECK;
         S_CHECK:       n = fifo_full ? S_FULL : S_IDLE_DECODE;
         S_WAIT_EMPTY:  n = (a != 2'b11 && empty[a]) ? S_FIRST : S_WAIT_EMPTY;
         default:       n = S_IDLE_DECODE;
      endcase
      return n;
   endfunction

   task automatic check(string tag);
      logic [7:0] obs, exp;
      obs = {detect_add, lfd_state, ld_state, laf_state, full_state,
             write_enb_reg, rst_int_reg, busy};
      exp = expected_outputs(ms);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s outputs observed=%b expected=%b", tag, obs, exp);
      end
      total++;
      assert (dut.addr === maddr) else begin
         bad++;
         $error("FAIL %s addr observed=%b expected=%b", tag, dut.addr, maddr);
      end
   endtask

   // One clock: model advances on the inputs present before the edge; checked #1 after it.
   task automatic tick(string tag);
      mstate_t    n;
      logic [1:0] na;
      n  = model_next(ms, maddr);
      na = (ms == S_IDLE_DECODE && pkt_valid && data_in != 2'b11) ? data_in : maddr;
      @(posedge clock);
      #1;
      ms    = n;
      maddr = na;
      check(tag);
   endtask

   task automatic async_reset(string tag);
      #2 reset = 1'b1;
      #1;
      ms    = S_IDLE_DECODE;
      maddr = 2'b00;
      check(tag);
      @(negedge clock);
      reset = 1'b0;
   endtask

   initial begin
      ms    = S_IDLE_DECODE;
      maddr = 2'b00;
      #12;
      check("reset");
      @(negedge clock);
      reset = 1'b0;

      // Normal packet to port 1.
      empty = 3'b010; pkt_valid = 1'b1; data_in = 2'b01;
      tick("pkt_hdr");
      for (int i = 0; i < 3; i++) begin
         data_in = 2'($urandom);
         tick("pkt_payload");
      end
      tick("pkt_ld3");
      pkt_valid = 1'b0;
      tick("pkt_lp");
      tick("pkt_cpe");
      tick("pkt_done");

      // Invalid header is ignored and leaves addr alone.
      pkt_valid = 1'b1; data_in = 2'b11;
      for (int i = 0; i < 5; i++) tick("invalid_hdr");

      // Wait for port 2 to drain, then into full handling.
      empty = 3'b000; data_in = 2'b10;
      tick("wte_enter");
      pkt_valid = 1'b0;
      for (int i = 0; i < 4; i++) tick("wte_hold");
      empty = 3'b100; pkt_valid = 1'b1;
      tick("wte_to_lfd");
      tick("lfd_to_ld");
      fifo_full = 1'b1;
      for (int i = 0; i < 3; i++) tick("ffs_hold");
      fifo_full = 1'b0; low_pkt_valid = 1'b1; parity_done = 1'b0; pkt_valid = 1'b0;
      tick("laf");
      tick("laf_to_lp");
      low_pkt_valid = 1'b0;
      tick("lp_to_cpe");
      tick("cpe_to_da");

      // Soft reset only on the selected port.
      empty = 3'b000; pkt_valid = 1'b1; data_in = 2'b00;
      tick("wte0_enter");
      pkt_valid = 1'b0; sr = 3'b010;
      tick("sr_other_port");
      sr = 3'b001;
      tick("sr_own_port");
      sr = 3'b000;

      // Reset mid-payload.
      empty = 3'b001; pkt_valid = 1'b1; data_in = 2'b00;
      tick("rst_hdr");
      tick("rst_ld");
      async_reset("reset_mid_ld");

      for (int i = 0; i < 600; i++) begin
         pkt_valid     = ($urandom_range(0, 3) != 0);
         data_in       = 2'($urandom);
         fifo_full     = ($urandom_range(0, 4) == 0);
         empty         = 3'($urandom);
         sr            = ($urandom_range(0, 15) == 0) ? 3'($urandom) : 3'b000;
         parity_done   = ($urandom_range(0, 3) == 0);
         low_pkt_valid = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 60) == 0) async_reset("rand_reset");
         else                            tick("random");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
